// File: rtl/axi_regfile_gen.sv
// -----------------------------------------------------------------------------
// axi_regfile_gen
//   Parametrised AXI4-Lite slave register file. NREGS 32-bit registers are
//   written over AXI (byte strobes honoured) and presented to user logic on
//   slv_reg. Reads return the user-supplied slv_read vector so status or FIFO
//   data can be mapped alongside control registers.
//
//   Per-register options:
//     RO_MASK[i]    : writes rejected with SLVERR, no update, no strobe
//     PULSE_MASK[i] : written value visible for one cycle, then RESET_VAL[i]
//     RESET_VAL[i]  : value loaded on reset
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET : clock, asynchronous active-high reset
//   slv_read   [NREGS][32] in : value returned for a read of register i
//   slv_reg    [NREGS][32] out: software-written register contents
//   slv_wr_stb [NREGS]     out: 1-cycle pulse per accepted OKAY write
//   slv_rd_stb [NREGS]     out: 1-cycle pulse per accepted OKAY read
//   S_AXI_AW*/W*/B*/AR*/R*    : AXI4-Lite slave channels (PROT ignored)
//
//   Responses: OKAY 2'b00, SLVERR 2'b10 (write to RO), DECERR 2'b11 (index
//   >= NREGS). One outstanding write and one outstanding read at a time.
// -----------------------------------------------------------------------------
module axi_regfile_gen #(
  parameter int                     NREGS              = 16,
  parameter int                     C_S_AXI_DATA_WIDTH = 32,
  parameter int                     C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [NREGS-1:0]       RO_MASK            = '0,
  parameter logic [NREGS-1:0]       PULSE_MASK         = '0,
  parameter logic [NREGS-1:0][31:0] RESET_VAL          = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [NREGS-1:0][31:0]          slv_read,
  output logic [NREGS-1:0][31:0]          slv_reg,
  output logic [NREGS-1:0]                slv_wr_stb,
  output logic [NREGS-1:0]                slv_rd_stb,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  generate
    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axi_regfile_gen: C_S_AXI_DATA_WIDTH must be 32");
    end
    if (NREGS < 1 || (2 ** IDXW) < NREGS) begin : g_bad_nregs
      $error("axi_regfile_gen: NREGS must be >= 1 and fit the address space");
    end
  endgenerate

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA}    r_state_e;

  // Write channel state. AWREADY/WREADY low in W_COLLECT means that half of
  // the transaction is already latched, so no separate "held" flags exist.
  w_state_e            w_state_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic [IDXW-1:0]     awidx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [NREGS-1:0]    wr_stb_q;

  // Read channel state
  r_state_e            r_state_q;
  logic                arready_q, rvalid_q;
  logic [1:0]          rresp_q;
  logic [31:0]         rdata_q;
  logic [NREGS-1:0]    rd_stb_q;

  logic [NREGS-1:0][31:0] slv_reg_q, slv_reg_d;

  // ---------------------------------------------------------------------------
  // Write decode: take each half from the bus on its handshake cycle, or from
  // the latch if it arrived earlier.
  // ---------------------------------------------------------------------------
  logic             aw_hs, w_hs, wr_commit;
  logic [IDXW-1:0]  wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic [NREGS-1:0] wr_hit, wr_en;
  logic [1:0]       wr_resp;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    aw_hs     = S_AXI_AWVALID & awready_q;
    w_hs      = S_AXI_WVALID & wready_q;
    wr_idx    = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_q;
    wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
    wr_commit = (w_state_q == W_COLLECT) && (aw_hs || !awready_q) && (w_hs || !wready_q);
    wr_hit    = '0;
    wr_resp   = RESP_DECERR;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_idx == IDXW'(i)) begin
        if (RO_MASK[i]) begin
          wr_resp = RESP_SLVERR;
        end else begin
          wr_resp   = RESP_OKAY;
          wr_hit[i] = 1'b1;
        end
      end
    end
    wr_en = wr_commit ? wr_hit : '0;
  end

  // Register next state. Pulse registers fall back to their reset value every
  // cycle they are not being written; a write merges onto that reset value.
  always_comb begin
    slv_reg_d = slv_reg_q;
    for (int i = 0; i < NREGS; i++) begin
      if (PULSE_MASK[i]) slv_reg_d[i] = RESET_VAL[i];
      if (wr_en[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) slv_reg_d[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // NOTE: slv_reg is a bank of individual flops with architectural reset
  // values, not a RAM, so it is reset along with the control state.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) slv_reg_q <= RESET_VAL;
    else              slv_reg_q <= slv_reg_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_COLLECT;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_stb_q  <= '0;
    end else begin
      wr_stb_q <= '0;
      unique case (w_state_q)
        W_COLLECT: begin
          if (aw_hs) awidx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (wr_commit) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
            wr_stb_q  <= wr_hit;
            w_state_q <= W_RESP;
          end else begin
            if (aw_hs) awready_q <= 1'b0;
            if (w_hs)  wready_q  <= 1'b0;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_COLLECT;
          end
        end
        default: w_state_q <= W_COLLECT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: slv_read is sampled on the AR handshake edge, so a write
  // committing on the same edge is not yet visible to that read.
  // ---------------------------------------------------------------------------
  logic             ar_hs;
  logic [IDXW-1:0]  ar_idx;
  logic [NREGS-1:0] rd_hit;
  logic [31:0]      rd_val;

  always_comb begin
    ar_hs  = S_AXI_ARVALID & arready_q;
    ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    rd_hit = '0;
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ar_idx == IDXW'(i)) begin
        rd_hit[i] = 1'b1;
        rd_val    = slv_read[i];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_stb_q  <= '0;
    end else begin
      rd_stb_q <= '0;
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_val;
            rresp_q   <= (|rd_hit) ? RESP_OKAY : RESP_DECERR;
            rd_stb_q  <= rd_hit;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // PROT and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign slv_reg       = slv_reg_q;
  assign slv_wr_stb    = wr_stb_q;
  assign slv_rd_stb    = rd_stb_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/axi_regfile_gen.md
Name: axi_regfile_gen

Overview:
- Parametrised AXI4-Lite slave register file. It is the successor to the fixed 16x32 register file on the PCIe-to-AXI M0x ports.
- Adds the following over the fixed version:
  - generic register count
  - per-register read-only and self-clearing (pulse) modes
  - per-register reset values
  - byte-strobe writes
  - per-register write/read strobes for user logic
  - DECERR/SLVERR responses
- Sits between the PCIe bridge AXI interconnect master port and user logic in the top level.

Parameters:
- NREGS, 16, number of 32-bit registers; must be >= 1.
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address bits decoded; 2**(C_S_AXI_ADDR_WIDTH-2) must be >= NREGS, otherwise elaboration error.
- RO_MASK, {NREGS{1'b0}}, bit i=1 makes register i read-only: writes are rejected with SLVERR.
- PULSE_MASK, {NREGS{1'b0}}, bit i=1 makes register i self-clearing: a written value persists exactly one cycle, then returns to its reset value.
- RESET_VAL, {NREGS{32'h0}}, packed NREGS x 32 reset value of slv_reg.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- slv_read  in  NREGS x 32  value returned on read of register i.
- slv_reg  out  NREGS x 32  software-written register contents.
- slv_wr_stb  out  NREGS  1-cycle pulse, bit i, on each accepted OKAY write to register i.
- slv_rd_stb  out  NREGS  1-cycle pulse, bit i, on each accepted OKAY read of register i (for FIFO pop etc).
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.

Behaviour:
- Reset values (asynchronous assert, values apply immediately):
  - slv_reg = RESET_VAL
  - AWREADY = WREADY = ARREADY = 1
  - BVALID = RVALID = 0
  - BRESP = RRESP = 0; RDATA = 0
  - strobes = 0
  - latched AW/W state discarded
- Address decode: idx = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored. idx >= NREGS gives DECERR (2'b11).
- Write channel FSM, states W_COLLECT and W_RESP. AW and W are accepted independently, in either order or in the same cycle:
  - AWREADY is high while no address is latched.
  - WREADY is high while no data is latched.
  - Once both are latched (at the edge of the later handshake): commit and enter W_RESP.
  - BVALID is high the cycle after the later handshake.
  - AWREADY and WREADY stay low in W_RESP.
- Write commit, for each byte b with WSTRB[b]=1: slv_reg[idx][8b+7:8b] <= WDATA byte. Responses:
  - RW register: BRESP OKAY; slv_wr_stb[idx] pulses in the commit cycle, coincident with the register update.
  - RO register: no update, SLVERR (2'b10), no strobe.
  - Out of range: DECERR, no update, no strobe.
  - WSTRB=0 on an RW register: OKAY, strobe still pulses, no data change.
- BVALID holds, with BRESP stable, until BREADY. On the handshake edge, return to W_COLLECT with AWREADY and WREADY high the next cycle. At most one outstanding write.
- Pulse registers (PULSE_MASK[i]=1): slv_reg[i] holds the written value for exactly one cycle, then reverts to RESET_VAL[i]. Back-to-back writes produce one pulse per write.
- Read channel FSM, states R_IDLE and R_DATA:
  - ARREADY = 1 in R_IDLE.
  - On the AR handshake: RDATA <= slv_read[idx] (OKAY, rd_stb pulse), or 0 (DECERR).
  - RVALID is high the next cycle (1-cycle latency).
  - ARREADY = 0 while RVALID is high.
  - RDATA and RRESP are held stable until RREADY; return to R_IDLE on that edge.
- RO registers read normally. Reads never return SLVERR.
- Read and write channels operate concurrently. When the AR handshake and a write commit hit the same register in the same cycle, the read samples the pre-write slv_read.
- Reset asserted mid-transaction: VALIDs drop asynchronously. No response is issued for the in-flight transaction.

Test Plan:
- Reset with RESET_VAL[3]=32'hA5A5_0000, read addr 0x0C → RDATA 32'hA5A5_0000, RRESP 00, rd_stb[3] one cycle; rvalid one cycle after AR handshake.
- W asserted 3 cycles before AW, write 0x08 = 32'h1234_5678 with WSTRB 4'b0101 over reset 0 → slv_reg[2] = 32'h0034_0078, BRESP 00, wr_stb[2] single pulse, BVALID one cycle after AW handshake.
- RO_MASK[1]=1, write 0x04 = 32'hFFFF_FFFF → BRESP 10, slv_reg[1] unchanged, no wr_stb; with NREGS=12, write and read at 0x30 → BRESP 11, RRESP 11, RDATA 0.
- PULSE_MASK[5]=1, write 0x14 = 32'h1 → slv_reg[5]=1 for exactly one cycle, then 0; BREADY held low 10 cycles → BVALID and BRESP stable, AWREADY and WREADY low throughout.
- Concurrent write 0x08 = 32'hCAFE and read 0x08 (slv_read[2]=slv_reg[2], old value 32'h0) in the same commit cycle → RDATA 32'h0; following read → 32'hCAFE; RREADY stalled 5 cycles keeps RDATA stable.
- Assert S_AXI_ARESET while BVALID=1 and RVALID=1 → both deassert immediately, slv_reg returns to RESET_VAL, and the first transaction after release completes normally.
